// File: rtl/sop_lut.sv
// Registered N-input sum-of-products evaluator with a run-time reloadable minterm mask
// (serial bit load) and a truth-table sweep that reports the minterm count.
module sop_lut #(
    parameter int unsigned          N    = 3,
    parameter logic [(2**N)-1:0]    INIT = 8'h75
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         out,
    output logic         out_valid,
    input  logic         load_start,
    input  logic         load_bit,
    input  logic         load_valid,
    output logic         load_done,
    input  logic         sweep_start,
    output logic [N-1:0] sweep_x,
    output logic         sweep_f,
    output logic         sweep_valid,
    output logic         sweep_done,
    output logic [N:0]   minterm_count,
    output logic         busy
);

    localparam int unsigned SIZE    = 2**N;
    localparam logic [N:0]  CNT_END = (N+1)'(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   mask_q, mask_d;
    logic [SIZE-1:0]   shadow_q, shadow_d;
    logic [N:0]        cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              load_done_q, load_done_d;
    logic [N-1:0]      sweep_x_q, sweep_x_d;
    logic              sweep_f_q, sweep_f_d;
    logic              sweep_valid_q, sweep_valid_d;
    logic              sweep_done_q, sweep_done_d;
    logic [N:0]        count_q, count_d;

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        load_done_d   = 1'b0;
        sweep_x_d     = sweep_x_q;
        sweep_f_d     = sweep_f_q;
        sweep_valid_d = 1'b0;
        sweep_done_d  = 1'b0;
        count_d       = count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_d       = mask_q[in];
                    out_valid_d = 1'b1;
                end
                // Load has priority; a coincident sweep request is dropped.
                if (load_start) begin
                    state_d  = LOAD;
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (sweep_start) begin
                    state_d       = SWEEP;
                    sweep_x_d     = '0;
                    sweep_f_d     = mask_q[0];
                    sweep_valid_d = 1'b1;
                    count_d       = '0;
                end
            end

            LOAD: begin
                if (load_valid) begin
                    shadow_d[cnt_q[N-1:0]] = load_bit;
                    cnt_d                  = cnt_q + 1'b1;
                    // Commit the whole shadow at once so no partial mask is ever used.
                    if (cnt_d == CNT_END) begin
                        mask_d      = shadow_d;
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            SWEEP: begin
                count_d = count_q + (N+1)'(sweep_f_q);
                if (sweep_x_q == '1) begin
                    sweep_f_d    = 1'b0;
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    sweep_x_d     = sweep_x_q + 1'b1;
                    sweep_f_d     = mask_q[sweep_x_d];
                    sweep_valid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mask_q        <= INIT;
            shadow_q      <= '0;
            cnt_q         <= '0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            load_done_q   <= 1'b0;
            sweep_x_q     <= '0;
            sweep_f_q     <= 1'b0;
            sweep_valid_q <= 1'b0;
            sweep_done_q  <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            load_done_q   <= load_done_d;
            sweep_x_q     <= sweep_x_d;
            sweep_f_q     <= sweep_f_d;
            sweep_valid_q <= sweep_valid_d;
            sweep_done_q  <= sweep_done_d;
            count_q       <= count_d;
        end
    end

    assign out           = out_q;
    assign out_valid     = out_valid_q;
    assign load_done     = load_done_q;
    assign sweep_x       = sweep_x_q;
    assign sweep_f       = sweep_f_q;
    assign sweep_valid   = sweep_valid_q;
    assign sweep_done    = sweep_done_q;
    assign minterm_count = count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sop_lut.sv
// Directed bench for sop_lut: a 3-input instance with the default mask and a
// 4-input instance with mask 16'h8001, sharing clock and reset.
module tb_sop_lut;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=3 instance
    logic [2:0] in_a;
    logic       in_valid_a, out_a, out_valid_a;
    logic       load_start_a, load_bit_a, load_valid_a, load_done_a;
    logic       sweep_start_a, sweep_f_a, sweep_valid_a, sweep_done_a, busy_a;
    logic [2:0] sweep_x_a;
    logic [3:0] minterm_count_a;

    // N=4 instance
    logic [3:0] in_b;
    logic       in_valid_b, out_b, out_valid_b;
    logic       load_start_b, load_bit_b, load_valid_b, load_done_b;
    logic       sweep_start_b, sweep_f_b, sweep_valid_b, sweep_done_b, busy_b;
    logic [3:0] sweep_x_b;
    logic [4:0] minterm_count_b;

    sop_lut #(.N(3), .INIT(8'h75)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in(in_a), .in_valid(in_valid_a), .out(out_a), .out_valid(out_valid_a),
        .load_start(load_start_a), .load_bit(load_bit_a), .load_valid(load_valid_a),
        .load_done(load_done_a), .sweep_start(sweep_start_a), .sweep_x(sweep_x_a),
        .sweep_f(sweep_f_a), .sweep_valid(sweep_valid_a), .sweep_done(sweep_done_a),
        .minterm_count(minterm_count_a), .busy(busy_a)
    );

    sop_lut #(.N(4), .INIT(16'h8001)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in(in_b), .in_valid(in_valid_b), .out(out_b), .out_valid(out_valid_b),
        .load_start(load_start_b), .load_bit(load_bit_b), .load_valid(load_valid_b),
        .load_done(load_done_b), .sweep_start(sweep_start_b), .sweep_x(sweep_x_b),
        .sweep_f(sweep_f_b), .sweep_valid(sweep_valid_b), .sweep_done(sweep_done_b),
        .minterm_count(minterm_count_b), .busy(busy_b)
    );

    typedef struct {
        logic [2:0] in;
        logic       exp;
    } eval_vec_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies eval vectors back-to-back, checking each result one cycle later.
    task automatic run_evals(input string tag, input eval_vec_t v[], input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            in_a       = v[i].in;
            in_valid_a = 1'b1;
            tick();
            check({tag, " out_valid"}, 32'(out_valid_a), 32'd1);
            check({tag, " out"}, 32'(out_a), 32'(v[i].exp));
        end
        in_valid_a = 1'b0;
    endtask

    // Full sweep on the N=3 instance against an expected mask and count.
    task automatic sweep_a(input logic [7:0] m, input int unsigned exp_cnt);
        sweep_start_a = 1'b1;
        tick();
        sweep_start_a = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            check("sweep_a valid", 32'(sweep_valid_a), 32'd1);
            check("sweep_a busy", 32'(busy_a), 32'd1);
            check("sweep_a x", 32'(sweep_x_a), i);
            check("sweep_a f", 32'(sweep_f_a), 32'(m[i]));
            check("sweep_a done early", 32'(sweep_done_a), 32'd0);
            tick();
        end
        check("sweep_a done", 32'(sweep_done_a), 32'd1);
        check("sweep_a busy end", 32'(busy_a), 32'd0);
        check("sweep_a valid end", 32'(sweep_valid_a), 32'd0);
        check("sweep_a count", 32'(minterm_count_a), exp_cnt);
        tick();
        check("sweep_a done pulse", 32'(sweep_done_a), 32'd0);
        check("sweep_a count hold", 32'(minterm_count_a), exp_cnt);
    endtask

    eval_vec_t ev_init[];
    eval_vec_t ev_loaded[];
    eval_vec_t ev_reset[];
    logic [7:0] m137;
    logic [7:0] m75;

    initial begin
        ev_init   = new[8];
        ev_loaded = new[3];
        ev_reset  = new[2];
        ev_init[0] = '{3'd0, 1'b1}; ev_init[1] = '{3'd1, 1'b0};
        ev_init[2] = '{3'd2, 1'b1}; ev_init[3] = '{3'd3, 1'b0};
        ev_init[4] = '{3'd4, 1'b1}; ev_init[5] = '{3'd5, 1'b1};
        ev_init[6] = '{3'd6, 1'b1}; ev_init[7] = '{3'd7, 1'b0};
        ev_loaded[0] = '{3'd3, 1'b1}; ev_loaded[1] = '{3'd7, 1'b1}; ev_loaded[2] = '{3'd0, 1'b0};
        ev_reset[0]  = '{3'd0, 1'b1}; ev_reset[1]  = '{3'd1, 1'b0};
        m137 = 8'b1000_1010;
        m75  = 8'h75;

        rst_n = 1'b0;
        in_a = '0; in_valid_a = 0; load_start_a = 0; load_bit_a = 0; load_valid_a = 0; sweep_start_a = 0;
        in_b = '0; in_valid_b = 0; load_start_b = 0; load_bit_b = 0; load_valid_b = 0; sweep_start_b = 0;
        tick();
        tick();
        check("rst out", 32'(out_a), 32'd0);
        check("rst out_valid", 32'(out_valid_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst sweep_valid", 32'(sweep_valid_a), 32'd0);
        check("rst load_done", 32'(load_done_a), 32'd0);
        check("rst count", 32'(minterm_count_a), 32'd0);
        rst_n = 1'b1;

        run_evals("init eval", ev_init, 8);
        tick();
        check("idle out_valid", 32'(out_valid_a), 32'd0);
        check("idle out hold", 32'(out_a), 32'd0);

        sweep_a(m75, 5);

        // Load m(1,3,7) with a two-cycle stall after bit 3.
        load_start_a = 1'b1;
        tick();
        load_start_a = 1'b0;
        check("load busy", 32'(busy_a), 32'd1);
        for (int unsigned k = 0; k < 8; k++) begin
            if (k == 4) begin
                load_valid_a = 1'b0;
                tick();
                check("load stall done", 32'(load_done_a), 32'd0);
                tick();
                check("load stall busy", 32'(busy_a), 32'd1);
            end
            load_valid_a = 1'b1;
            load_bit_a   = m137[k];
            tick();
            check("load done", 32'(load_done_a), (k == 7) ? 32'd1 : 32'd0);
        end
        load_valid_a = 1'b0;
        check("load busy end", 32'(busy_a), 32'd0);
        run_evals("loaded eval", ev_loaded, 3);
        sweep_a(m137, 3);

        // Reset after four bits of an all-ones load: mask returns to INIT.
        load_start_a = 1'b1;
        tick();
        load_start_a = 1'b0;
        load_valid_a = 1'b1;
        load_bit_a   = 1'b1;
        for (int unsigned k = 0; k < 4; k++) tick();
        load_valid_a = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midload rst busy", 32'(busy_a), 32'd0);
        check("midload rst done", 32'(load_done_a), 32'd0);
        tick();
        check("midload rst done later", 32'(load_done_a), 32'd0);
        run_evals("post reset eval", ev_reset, 2);

        // Coincident starts: load wins; in_valid is ignored while loading.
        tick();
        load_start_a  = 1'b1;
        sweep_start_a = 1'b1;
        tick();
        load_start_a  = 1'b0;
        sweep_start_a = 1'b0;
        check("both start busy", 32'(busy_a), 32'd1);
        check("both start no sweep", 32'(sweep_valid_a), 32'd0);
        for (int unsigned k = 0; k < 8; k++) begin
            in_a         = 3'd0;
            in_valid_a   = 1'b1;
            load_valid_a = 1'b1;
            load_bit_a   = m75[k];
            tick();
            check("load ignore eval", 32'(out_valid_a), 32'd0);
            check("load no sweep", 32'(sweep_valid_a), 32'd0);
        end
        in_valid_a   = 1'b0;
        load_valid_a = 1'b0;
        check("reload done", 32'(load_done_a), 32'd1);
        // Start in the load_done cycle is accepted.
        sweep_a(m75, 5);

        // N=4 instance: f=1 only at x=0 and x=15, sweep lasts 16 cycles.
        sweep_start_b = 1'b1;
        tick();
        sweep_start_b = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            check("sweep_b valid", 32'(sweep_valid_b), 32'd1);
            check("sweep_b x", 32'(sweep_x_b), i);
            check("sweep_b f", 32'(sweep_f_b), (i == 0 || i == 15) ? 32'd1 : 32'd0);
            tick();
        end
        check("sweep_b done", 32'(sweep_done_b), 32'd1);
        check("sweep_b busy", 32'(busy_b), 32'd0);
        check("sweep_b count", 32'(minterm_count_b), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sop_lut.md
# sop_lut

Parametrised, registered sum-of-products evaluator. Implements any N-input Boolean function f = SUM m(...) held as a 2^N-bit minterm mask. The mask is reloadable at run time through a serial bit handshake. A sweep mode walks every input combination and reports the truth table and the minterm count. Sits in the Digital Circuits lab datapath as the programmable successor to the fixed 3-input canonical SOP block.

## Interface
- N, 3, number of function inputs (1..8)
- INIT, 8'h75, reset minterm mask, bit k = f(k); default is m(0,2,4,5,6)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in  in  N  input combination to evaluate
- in_valid  in  1  evaluate `in` this cycle
- out  out  1  registered f(in)
- out_valid  out  1  `out` is valid this cycle
- load_start  in  1  begin serial mask load
- load_bit  in  1  next mask bit, minterm 0 first
- load_valid  in  1  `load_bit` is valid this cycle
- load_done  out  1  one-cycle pulse, new mask committed
- sweep_start  in  1  begin truth-table sweep
- sweep_x  out  N  current sweep combination
- sweep_f  out  1  mask[sweep_x]
- sweep_valid  out  1  sweep_x/sweep_f valid
- sweep_done  out  1  one-cycle pulse, sweep finished
- minterm_count  out  N+1  number of 1s in mask, from last sweep
- busy  out  1  high in LOAD or SWEEP

## Operation
- FSM states: IDLE, LOAD, SWEEP, all one-hot or encoded; reset → IDLE.
- IDLE:
  - in_valid=1 → out=mask[in], out_valid=1 next cycle.
  - load_start=1 → LOAD; shadow register and bit counter cleared.
  - sweep_start=1 → SWEEP; index and minterm_count cleared.
  - If both starts are asserted together, load wins and sweep_start is dropped.
- LOAD:
  - Each cycle with load_valid=1 writes load_bit to shadow[cnt], then cnt increments (width N+1).
  - load_valid=0 cycles are stalls with no change.
  - When cnt reaches 2^N: mask ← shadow atomically, load_done pulses, → IDLE.
  - The old mask stays in use until commit. No partial update is ever visible.
- SWEEP: one combination per cycle, index 0 → 2^N-1.
  - sweep_valid=1, sweep_x=index, sweep_f=mask[index].
  - Count increments when sweep_f=1.
  - After the last index: sweep_done pulses, → IDLE.
- In LOAD/SWEEP:
  - in_valid, load_start and sweep_start are ignored; out_valid=0.
  - load_valid is ignored outside LOAD.
- minterm_count holds its value until the next sweep_start is accepted, then clears to 0.
- out holds its last value when out_valid=0.

## Timing
- Reset (rst_n=0 at a clk edge):
  - mask=INIT, state=IDLE.
  - out, out_valid, load_done, sweep_x, sweep_f, sweep_valid, sweep_done, busy all 0; minterm_count=0.
  - Shadow and counters cleared.
- Reset mid-LOAD discards the shadow; mask returns to INIT, not the pre-load mask.
- Reset mid-SWEEP aborts the sweep; no sweep_done is issued.
- Evaluate latency: in/in_valid sampled at edge t → out/out_valid at t+1. Back-to-back every cycle.
- A start sampled at edge t → busy=1 from t+1.
- LOAD with no stalls:
  - Bits are sampled at edges t+1 … t+2^N.
  - load_done=1 and new mask active for eval from t+2^N+1.
  - busy drops in that same cycle.
- SWEEP:
  - sweep_valid=1 for cycles t+1 … t+2^N, with sweep_x = 0 … 2^N-1.
  - sweep_done=1 and final minterm_count at t+2^N+1; busy=0 in that cycle.
- A start asserted in the load_done/sweep_done cycle is accepted (FSM is IDLE).

## Test plan
- Reset with N=3, INIT=8'h75; evaluate in=0..7 back-to-back → out = 1,0,1,0,1,1,1,0, each one cycle after its input; out_valid high 8 cycles.
- sweep_start → sweep_x 0..7 over 8 consecutive cycles with sweep_f = 1,0,1,0,1,1,1,0; sweep_done next cycle; minterm_count=5; busy high exactly 8 cycles.
- Load m(1,3,7) as bits 0,1,0,1,0,0,0,1 with load_valid dropped for 2 cycles mid-stream → load_done once after the 8th bit. Then in=3→1, in=7→1, in=0→0; sweep gives minterm_count=3.
- Assert rst_n=0 after 4 load bits → busy=0, no load_done; in=0→1 and in=1→0 (mask back to 8'h75).
- Assert load_start and sweep_start in the same IDLE cycle; also pulse in_valid during LOAD → LOAD entered, no sweep_valid, out_valid stays 0 until return to IDLE.
- N=4, INIT=16'h8001 → sweep shows f=1 only at x=0 and x=15; minterm_count=2; sweep lasts 16 cycles.
